// File: rtl/seq_sub64.sv
// Multi-cycle subtractor: {b_out, diff} = A - B - b_in, computed SLICE bits per
// clock (least-significant slice first) behind a start/busy/done handshake.
module seq_sub64 #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic             borrow_q, borrow_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             b_out_q, b_out_d;
   logic             ovf_q, ovf_d;

   logic [SLICE:0]   slice_sum;
   logic [WIDTH-1:0] part_full;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      part_d   = part_q;
      borrow_d = borrow_q;
      k_d      = k_q;
      diff_d   = diff_q;
      b_out_d  = b_out_q;
      ovf_d    = ovf_q;

      // Subtraction as A + ~B + ~borrow; carry out of the slice is the inverted borrow.
      slice_sum = {1'b0, a_q[k_q*SLICE +: SLICE]}
                + {1'b0, ~b_q[k_q*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, ~borrow_q};
      part_full = part_q;
      part_full[k_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d      = A;
               b_d      = B;
               borrow_d = b_in;
               part_d   = '0;
               k_d      = '0;
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            part_d   = part_full;
            borrow_d = ~slice_sum[SLICE];
            k_d      = k_q + KW'(1);
            if (k_q == K_LAST) begin
               // Publish only the completed result; partial slices stay internal.
               diff_d  = part_full;
               b_out_d = ~slice_sum[SLICE];
               ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ part_full[WIDTH-1]);
               k_d     = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         part_q   <= '0;
         borrow_q <= 1'b0;
         k_q      <= '0;
         diff_q   <= '0;
         b_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         part_q   <= part_d;
         borrow_q <= borrow_d;
         k_q      <= k_d;
         diff_q   <= diff_d;
         b_out_q  <= b_out_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign diff  = diff_q;
   assign b_out = b_out_q;
   assign ovf   = ovf_q;

endmodule
